jtag_tap_sync: RTL
==================

# jtag_tap_sync

JTAG target-side TAP controller that responds to the VPI JTAG driver's TCK/TMS/TDI stream and returns TDO. It oversamples the JTAG pins on a single system clock and implements the IEEE 1149.1 16-state TAP FSM. It provides an instruction register and IDCODE, BYPASS and USER data registers. The USER register gives simulated debug logic a 32-bit read/write window reachable from the JTAG server.

## Interface

**Parameters**
- `IR_WIDTH`, 4: instruction register width.
- `IDCODE_VALUE`, 32'h149511c3: value captured into the IDCODE DR.
- `IDCODE_OPCODE`, 4'h1: IR value selecting IDCODE; also the IR reset value.
- `USER_OPCODE`, 4'h8: IR value selecting the USER DR.
- `USER_WIDTH`, 32: USER DR width.

**Ports** (clock and reset first)
- `clk` input, 1: system clock. All logic is clocked on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `tck` input, 1: JTAG clock, asynchronous to `clk`.
- `tms` input, 1: JTAG mode select.
- `tdi` input, 1: JTAG data in.
- `tdo` output, 1: JTAG data out.
- `tdo_oe` output, 1: high while TDO is valid (Shift-IR/Shift-DR).
- `user_dr_in` input, USER_WIDTH: value loaded into the USER DR at Capture-DR.
- `user_dr_out` output, USER_WIDTH: USER DR contents latched at Update-DR.
- `user_capture` output, 1: 1-clk pulse on Capture-DR with IR=USER_OPCODE.
- `user_update` output, 1: 1-clk pulse on Update-DR with IR=USER_OPCODE.
- `tap_state` output, 4: current TAP state encoding.
- `ir` output, IR_WIDTH: current instruction.

## Operation

**Pin sampling**
- `tck`, `tms` and `tdi` each pass through a 2-FF synchronizer.
- A third `tck` register drives edge detection.
- `tck_rise` = synchronized 0→1; `tck_fall` = synchronized 1→0.
- TMS/TDI are used from the same synchronizer stage as the `tck` value that produced the edge.

**TAP FSM**
- The FSM advances only on `tck_rise`.
- State encodings: TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8, SelIR=9, CapIR=10, ShIR=11, Ex1IR=12, PauIR=13, Ex2IR=14, UpdIR=15.
- Transitions follow IEEE 1149.1.
- TMS=1 for 5 consecutive rising edges reaches TLR from any state.

**Register actions** (on `tck_rise`, according to the state being exited)
- CapIR: IR shift register ← {0…0,01}.
- ShIR: IR shift register ← {tdi, sr[IR_WIDTH-1:1]} (LSB first, matching the driver's bit order).
- UpdIR: `ir` ← IR shift register.
- CapDR loads the DR selected by `ir`:
  - IDCODE_OPCODE: IDCODE_VALUE.
  - USER_OPCODE: `user_dr_in`.
  - Any other value, including all-ones: the 1-bit BYPASS register ← 0.
- ShDR: the selected DR shifts right, with `tdi` entering the MSB.
- UpdDR with USER selected: `user_dr_out` ← shift register, and `user_update` pulses.
- Entering TLR: `ir` ← IDCODE_OPCODE.

**TDO**
- On `tck_fall`: `tdo` ← LSB of the active shift register.
- On `tck_fall`: `tdo_oe` ← (state is ShIR or ShDR).
- When not shifting, `tdo` is held at 0.

**Reset**
- Reset values: `tap_state`=TLR, `ir`=IDCODE_OPCODE, all shift registers 0, `tdo`=0, `tdo_oe`=0, `user_dr_out`=0, `user_capture`=0, `user_update`=0, synchronizers 0.
- `rst` overrides a simultaneous `tck` edge.
- A reset asserted mid-scan discards the partial shift, with no Update pulse.

## Timing

- `clk` must be ≥ 4× TCK frequency, with TCK high and low phases each ≥ 2 `clk` periods. At the driver's default 100 ns TCK period, `clk` ≥ 40 MHz.
- Pin edge to `tck_rise`/`tck_fall` pulse: 3 `clk` cycles.
- FSM/register update occurs 1 cycle after the pulse.
- TDO becomes valid ≤ 4 `clk` after the TCK falling edge, well before the driver's next rising-edge sample.
- `user_capture` and `user_update` are exactly 1 `clk` wide, asserted in the cycle the FSM leaves CapDR/UpdDR.
- `user_dr_in` must be stable for 1 `clk` around the `tck_rise` that exits CapDR.
- IR or TMS glitches shorter than 2 `clk` are not guaranteed to be filtered.

## Test plan

1. **Reset and IR default.** Pulse `rst`, then 5 TCK with TMS=1 and 1 TCK with TMS=0 → `tap_state`=1 (RTI), `ir`=4'h1, `tdo_oe`=0.
2. **IDCODE read.**
   - Stimulus: from RTI, TMS 1,0,0; then 32 bits TDI=0 with TMS=1 on the last bit; then TMS 1,0.
   - Required: the TDO stream (LSB first) assembles to 32'h149511c3, and the FSM ends in RTI.
3. **IR scan.**
   - Stimulus: TMS 1,1,0,0 → ShIR; shift 4'h8 LSB first, flip TMS on the last bit; then Update.
   - Required: the first TDO bits shifted out are 1,0,0,0; `ir`=4'h8.
4. **USER DR write/read.**
   - Stimulus: with `ir`=8 and `user_dr_in`=32'hDEADBEEF, shift in 32'hCAFEF00D.
   - Required:
     - TDO reads 32'hDEADBEEF.
     - `user_capture` pulses once.
     - After Update-DR, `user_dr_out`=32'hCAFEF00D and `user_update` pulses exactly 1 `clk`.
5. **BYPASS.**
   - Stimulus: set `ir`=4'hF; shift 9 bits, TDI = 0xA5 (LSB first) followed by 0.
   - Required: the TDO stream is 0 then the bits of 0xA5, i.e. one-bit delay; an unknown IR such as 4'h3 behaves identically.
6. **Reset mid-scan.**
   - Stimulus: assert `rst` during ShDR after 10 USER bits.
   - Required:
     - `tap_state`=0 (TLR), `tdo_oe`=0, `ir`=4'h1.
     - `user_dr_out`=0, with no `user_update` pulse.
     - Separately, 5 TMS=1 edges from ShDR reach TLR.

Source files
------------

// File: rtl/jtag_tap_sync.sv
// JTAG TAP controller running entirely in the clk domain: TCK/TMS/TDI are oversampled,
// and the IEEE 1149.1 state machine advances on each detected TCK rising edge.
module jtag_tap_sync #(
    parameter int                    IR_WIDTH      = 4,
    parameter logic [31:0]           IDCODE_VALUE  = 32'h149511c3,
    parameter logic [IR_WIDTH-1:0]   IDCODE_OPCODE = 4'h1,
    parameter logic [IR_WIDTH-1:0]   USER_OPCODE   = 4'h8,
    parameter int                    USER_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tck,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_oe,
    input  logic [USER_WIDTH-1:0] user_dr_in,
    output logic [USER_WIDTH-1:0] user_dr_out,
    output logic                  user_capture,
    output logic                  user_update,
    output logic [3:0]            tap_state,
    output logic [IR_WIDTH-1:0]   ir
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    function automatic tap_state_e next_state(input tap_state_e cur, input logic tms_v);
        case (cur)
            TLR:     next_state = tms_v ? TLR    : RTI;
            RTI:     next_state = tms_v ? SEL_DR : RTI;
            SEL_DR:  next_state = tms_v ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms_v ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms_v ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms_v ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms_v ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms_v ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms_v ? SEL_DR : RTI;
            SEL_IR:  next_state = tms_v ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms_v ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms_v ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms_v ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms_v ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms_v ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms_v ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    endfunction

    logic [2:0]            tck_sync_q, tck_sync_d;
    logic [1:0]            tms_sync_q, tms_sync_d;
    logic [1:0]            tdi_sync_q, tdi_sync_d;
    tap_state_e            state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [31:0]           idcode_sr_q, idcode_sr_d;
    logic [USER_WIDTH-1:0] user_sr_q, user_sr_d, user_dr_out_q, user_dr_out_d;
    logic                  bypass_q, bypass_d;
    logic                  tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
    logic                  user_capture_q, user_capture_d, user_update_q, user_update_d;

    logic tck_rise_s, tck_fall_s, tms_s, tdi_s, sel_idcode_s, sel_user_s, dr_lsb_s;

    // TMS/TDI come from the same stage as the newer TCK sample used for edge detection.
    assign tck_rise_s   = tck_sync_q[1] & ~tck_sync_q[2];
    assign tck_fall_s   = ~tck_sync_q[1] & tck_sync_q[2];
    assign tms_s        = tms_sync_q[1];
    assign tdi_s        = tdi_sync_q[1];
    assign sel_idcode_s = (ir_q == IDCODE_OPCODE);
    assign sel_user_s   = (ir_q == USER_OPCODE);
    assign dr_lsb_s     = sel_idcode_s ? idcode_sr_q[0] : (sel_user_s ? user_sr_q[0] : bypass_q);

    // Next-state logic for the synchronizers, TAP FSM, shift registers and TDO.
    always_comb begin
        tck_sync_d     = {tck_sync_q[1:0], tck};
        tms_sync_d     = {tms_sync_q[0], tms};
        tdi_sync_d     = {tdi_sync_q[0], tdi};
        state_d        = state_q;
        ir_d           = ir_q;
        ir_sr_d        = ir_sr_q;
        idcode_sr_d    = idcode_sr_q;
        user_sr_d      = user_sr_q;
        user_dr_out_d  = user_dr_out_q;
        bypass_d       = bypass_q;
        tdo_d          = tdo_q;
        tdo_oe_d       = tdo_oe_q;
        user_capture_d = 1'b0;
        user_update_d  = 1'b0;

        if (tck_rise_s) begin
            state_d = next_state(state_q, tms_s);
            case (state_q)
                CAP_IR: ir_sr_d = {{(IR_WIDTH-2){1'b0}}, 2'b01};
                SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
                UPD_IR: ir_d    = ir_sr_q;
                CAP_DR: begin
                    if (sel_idcode_s) begin
                        idcode_sr_d = IDCODE_VALUE;
                    end else if (sel_user_s) begin
                        user_sr_d      = user_dr_in;
                        user_capture_d = 1'b1;
                    end else begin
                        bypass_d = 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_idcode_s) begin
                        idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
                    end else if (sel_user_s) begin
                        user_sr_d = {tdi_s, user_sr_q[USER_WIDTH-1:1]};
                    end else begin
                        bypass_d = tdi_s;
                    end
                end
                UPD_DR: begin
                    if (sel_user_s) begin
                        user_dr_out_d = user_sr_q;
                        user_update_d = 1'b1;
                    end else begin
                        user_dr_out_d = user_dr_out_q;
                    end
                end
                default: ir_sr_d = ir_sr_q;
            endcase
            if (state_d == TLR) begin
                ir_d = IDCODE_OPCODE;
            end else begin
                ir_d = ir_d;
            end
        end else if (tck_fall_s) begin
            tdo_oe_d = (state_q == SH_IR) || (state_q == SH_DR);
            case (state_q)
                SH_IR:   tdo_d = ir_sr_q[0];
                SH_DR:   tdo_d = dr_lsb_s;
                default: tdo_d = 1'b0;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State register; rst wins over any TCK edge seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tck_sync_q     <= 3'b000;
            tms_sync_q     <= 2'b00;
            tdi_sync_q     <= 2'b00;
            state_q        <= TLR;
            ir_q           <= IDCODE_OPCODE;
            ir_sr_q        <= '0;
            idcode_sr_q    <= 32'h0000_0000;
            user_sr_q      <= '0;
            user_dr_out_q  <= '0;
            bypass_q       <= 1'b0;
            tdo_q          <= 1'b0;
            tdo_oe_q       <= 1'b0;
            user_capture_q <= 1'b0;
            user_update_q  <= 1'b0;
        end else begin
            tck_sync_q     <= tck_sync_d;
            tms_sync_q     <= tms_sync_d;
            tdi_sync_q     <= tdi_sync_d;
            state_q        <= state_d;
            ir_q           <= ir_d;
            ir_sr_q        <= ir_sr_d;
            idcode_sr_q    <= idcode_sr_d;
            user_sr_q      <= user_sr_d;
            user_dr_out_q  <= user_dr_out_d;
            bypass_q       <= bypass_d;
            tdo_q          <= tdo_d;
            tdo_oe_q       <= tdo_oe_d;
            user_capture_q <= user_capture_d;
            user_update_q  <= user_update_d;
        end
    end

    assign tdo          = tdo_q;
    assign tdo_oe       = tdo_oe_q;
    assign user_dr_out  = user_dr_out_q;
    assign user_capture = user_capture_q;
    assign user_update  = user_update_q;
    assign tap_state    = state_q;
    assign ir           = ir_q;

endmodule
